gecko_supervisor_arbiter: RTL

Two-port round-robin arbiter that shares the single supervisor memory port of `gecko_micro` between two requesters. Typical pairing: the AXI4 slave bridge on port 0 and a debug/loader engine on port 1. It forwards one request per handshake to the shared port. A tag FIFO records which requester issued each read, so in-order read responses are routed back to the correct requester.

---
 rtl/gecko_supervisor_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/gecko_supervisor_arbiter.sv
// gecko_supervisor_arbiter
//   Two-port round-robin arbiter in front of the gecko_micro supervisor memory
//   port. One request is forwarded per handshake. Reads record their requester
//   index in a tag FIFO so that in-order read responses are steered back to the
//   requester that issued them.
//
// Ports (std_mem_intf bundles flattened as <port>_<field>):
//   clk, rst                 clock, async active-low reset
//   req0_*, req1_*           requester inputs  (valid/ready/read_write/addr/data)
//   resp0_*, resp1_*         read responses    (valid/ready/data)
//   mem_request_*            shared request port towards the supervisor
//   mem_response_*           shared response port from the supervisor
//   outstanding              reads issued but not yet answered (registered)
//   unexpected_response      sticky: response seen while no read was pending
//   grant_count0/1           accepted-request counters
//
// Build option: GECKO_SUPERVISOR_ARBITER_COUNTERS_EN builds the grant counters;
// without it grant_count0/1 are tied to zero.
module gecko_supervisor_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req0_valid,
  output logic                                 req0_ready,
  input  logic                                 req0_read_write,
  input  logic [ADDR_WIDTH-1:0]                req0_addr,
  input  logic [DATA_WIDTH-1:0]                req0_data,
  input  logic                                 req1_valid,
  output logic                                 req1_ready,
  input  logic                                 req1_read_write,
  input  logic [ADDR_WIDTH-1:0]                req1_addr,
  input  logic [DATA_WIDTH-1:0]                req1_data,
  output logic                                 resp0_valid,
  input  logic                                 resp0_ready,
  output logic [DATA_WIDTH-1:0]                resp0_data,
  output logic                                 resp1_valid,
  input  logic                                 resp1_ready,
  output logic [DATA_WIDTH-1:0]                resp1_data,
  output logic                                 mem_request_valid,
  input  logic                                 mem_request_ready,
  output logic                                 mem_request_read_write,
  output logic [ADDR_WIDTH-1:0]                mem_request_addr,
  output logic [DATA_WIDTH-1:0]                mem_request_data,
  input  logic                                 mem_response_valid,
  output logic                                 mem_response_ready,
  input  logic [DATA_WIDTH-1:0]                mem_response_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 unexpected_response,
  output logic [31:0]                          grant_count0,
  output logic [31:0]                          grant_count1
);

  localparam int PW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  // Requesters gathered into arrays so the mux is indexed by sel.
  logic [1:0]                 rq_valid, rq_rw;
  logic [1:0][ADDR_WIDTH-1:0] rq_addr;
  logic [1:0][DATA_WIDTH-1:0] rq_data;

  assign rq_valid = {req1_valid, req0_valid};
  assign rq_rw    = {req1_read_write, req0_read_write};
  assign rq_addr  = {req1_addr, req0_addr};
  assign rq_data  = {req1_data, req0_data};

  logic prio_q, prio_d, locked_q, locked_d, lock_idx_q, lock_idx_d, unexp_q, unexp_d;
  logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [OW-1:0]              cnt_q, cnt_d;

  logic sel, sel_valid, sel_rw, full, empty, block, grant, hs, push, pop, head;

  // Request selection: a held lock wins, then a lone requester, then prio.
  always_comb begin
    if (locked_q)        sel = lock_idx_q;
    else if (&rq_valid)  sel = prio_q;
    else                 sel = rq_valid[1];
  end

  assign sel_valid = rq_valid[sel];
  assign sel_rw    = rq_rw[sel];

  // Pointers carry one extra wrap bit: equal low bits with differing MSB = full.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                 (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
  assign head  = tag_q[rptr_q[PW-2:0]];

  // Block uses the registered full flag only; a same-cycle pop does not free
  // the slot, which keeps the response path out of the request path.
  assign block = ~sel_rw & full;
  assign grant = mem_request_ready & ~block;
  assign hs    = sel_valid & grant;
  assign push  = hs & ~sel_rw;

  assign mem_request_valid      = sel_valid & ~block;
  assign mem_request_read_write = sel_rw;
  assign mem_request_addr       = rq_addr[sel];
  assign mem_request_data       = rq_data[sel];
  assign req0_ready             = grant & ~sel;
  assign req1_ready             = grant & sel;

  // Response routing. With nothing pending the response is swallowed.
  assign resp0_valid        = ~empty & ~head & mem_response_valid;
  assign resp1_valid        = ~empty &  head & mem_response_valid;
  assign resp0_data         = mem_response_data;
  assign resp1_data         = mem_response_data;
  assign mem_response_ready = empty | (head ? resp1_ready : resp0_ready);
  assign pop                = ~empty & mem_response_valid & mem_response_ready;

  always_comb begin
    prio_d     = prio_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    unexp_d    = unexp_q | (empty & mem_response_valid);

    if (hs) begin
      locked_d = 1'b0;
      prio_d   = ~sel;
    end else if (sel_valid) begin
      // Hold the presented request until it is accepted.
      locked_d   = 1'b1;
      lock_idx_d = sel;
    end else begin
      locked_d = 1'b0;
    end

    if (push) begin
      tag_d[wptr_q[PW-2:0]] = sel;
      wptr_d                = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + OW'(1);
      2'b01:   cnt_d = cnt_q - OW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q     <= 1'b0;
      locked_q   <= 1'b0;
      lock_idx_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      unexp_q    <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      unexp_q    <= unexp_d;
    end
  end

  assign outstanding         = cnt_q;
  assign unexpected_response = unexp_q;

`ifdef GECKO_SUPERVISOR_ARBITER_COUNTERS_EN
  logic [31:0] gc0_q, gc1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gc0_q <= '0;
      gc1_q <= '0;
    end else begin
      if (hs & ~sel) gc0_q <= gc0_q + 32'd1;
      if (hs &  sel) gc1_q <= gc1_q + 32'd1;
    end
  end

  assign grant_count0 = gc0_q;
  assign grant_count1 = gc1_q;
`else
  assign grant_count0 = '0;
  assign grant_count1 = '0;
`endif

endmodule
